if_fetch: RTL
=============

Name: if_fetch

Overview:
IF stage of the 5-stage MIPS pipeline; the producer end of the IF→ID interface. Owns the PC register and drives the synchronous instruction SRAM. Emits if_to_id_bus {ce, pc} and an aligned instruction word. Consumes the ID branch bus {br_e, br_addr} and the stall vector. Holds the fetched word across ID stalls, so ID always sees the instruction belonging to its latched PC.

Parameters:
RESET_PC, 32'hBFBF_FFFC, PC register value after reset; first fetched address is RESET_PC+4 = 32'hBFC0_0000.
STALL_W, 6, stall vector width; bit0 = PC, bit1 = IF, bit2 = ID; 1 = Stop.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  STALL_W  pipeline stall vector, 1 = Stop
br_bus  in  33  {br_e[32], br_addr[31:0]} from ID, combinational, same cycle
if_to_id_bus  out  33  {ce[32], pc[31:0]} registered
id_inst  out  32  instruction word aligned to ID's latched PC
inst_sram_en  out  1  SRAM enable, equals ce
inst_sram_wen  out  4  tied 4'b0000
inst_sram_addr  out  32  equals pc_reg
inst_sram_wdata  out  32  tied 0
inst_sram_rdata  in  32  read data, valid one cycle after the address is presented

Behaviour:
- Reset (rst=1 at posedge):
  - pc_reg ← RESET_PC; ce ← 0.
  - pend_valid ← 0; pend_addr ← 0.
  - hold_valid ← 0; hold_reg ← 0; bubble ← 0; FSM ← S_RST.
  - Outputs during and after reset: if_to_id_bus = {1'b0, RESET_PC}; inst_sram_en = 0; id_inst = 0.
- Reset asserted mid-operation has priority over every other update, including a pending branch or a held word.
- next_pc selection, in priority order:
  - br_e → br_addr
  - pend_valid → pend_addr
  - otherwise → pc_reg + 4, wrapping modulo 2^32.
- PC update at each posedge with rst=0:
  - stall[0]=NoStop: pc_reg ← next_pc; ce ← 1; pend_valid ← 0.
  - stall[0]=Stop: pc_reg and ce hold.
- Delay slot: the branch in ID resolves while IF fetches branch+4. The redirect takes effect on the next fetch, so the delay slot is never squashed.
- Pending branch: if br_e=1, stall[0]=Stop and stall[2]=NoStop, then pend_valid ← 1 and pend_addr ← br_addr.
  - A later pend capture overwrites an earlier one.
  - br_e while stall[2]=Stop is not captured; ID re-evaluates that branch itself.
- Hold buffer (SRAM latency is 1 cycle):
  - stall[2]=Stop and hold_valid=0 → hold_reg ← inst_sram_rdata; hold_valid ← 1.
  - stall[2]=NoStop → hold_valid ← 0.
- Bubble register: bubble ← (stall[1]=Stop and stall[2]=NoStop).
- id_inst selection:
  - bubble → 0
  - hold_valid → hold_reg
  - ce=0 → 0
  - otherwise → inst_sram_rdata.
- FSM:
  - S_RST: ce=0. Moves to S_RUN on the first cycle with rst=0 and stall[0]=NoStop.
  - S_RUN: moves to S_HOLD when stall[2]=Stop.
  - S_HOLD: hold_valid=1. Moves to S_RUN when stall[2]=NoStop.
  - rst from any state → S_RST.
- inst_sram_en is 0 throughout S_RST.
- The state is exported only through the registered signals above; no combinational path from stall to inst_sram_addr.

Test Plan:
- Reset, then 4 free-running cycles → inst_sram_addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; ce=0 during reset, 1 from the first post-reset cycle.
- br_e=1, br_addr=0xBFC00100 while pc_reg=0xBFC00008 → next addr 0xBFC00100; the word at 0xBFC00008 (delay slot) still reaches id_inst.
- Load-use stall: stall=6'b000111 for 2 cycles while ID pc=0xBFC00010 with SRAM word 0x8C220000 → id_inst stays 0x8C220000 through both cycles even though rdata changes; correct word follows on release.
- stall=6'b000011 with br_e=1, br_addr=0xBFC00200 → pend captured; on release addr=0xBFC00200, pend_valid=0; id_inst=0 in the bubble cycle.
- pc_reg=0xFFFFFFFC, no stall or branch → next addr 0x00000000.
- rst mid-run with pend_valid=1 and hold_valid=1 → both cleared; addr restarts at 0xBFC00000.

Source files
------------

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_if
//  Description : Instruction SRAM bus between the IF stage and the
//                synchronous instruction memory.
//                  inst_sram_en    - read enable (fetch stage -> SRAM)
//                  inst_sram_wen   - byte write enables, never asserted
//                  inst_sram_addr  - fetch address
//                  inst_sram_wdata - write data, unused by instruction fetch
//                  inst_sram_rdata - read data, one cycle after the address
//                master = fetch stage, slave = SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the
//                PC, drives the synchronous instruction SRAM and presents the
//                instruction word aligned to the PC latched by ID.
//  Ports       : clk          - clock
//                rst          - synchronous active-high reset
//                stall        - stall vector, bit0 PC, bit1 IF, bit2 ID (1=stop)
//                br_bus       - {br_e, br_addr} from ID, same-cycle
//                if_to_id_bus - {ce, pc} registered
//                id_inst      - instruction word for ID's latched PC
//                sram         - instruction SRAM bus (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = 6
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [STALL_W-1:0] stall,
  input  wire logic [32:0]        br_bus,
  output logic      [32:0]        if_to_id_bus,
  output logic      [31:0]        id_inst,
  if_fetch_if.master              sram
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic        ce;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        hold_valid;
  logic [31:0] hold_reg;
  logic        bubble;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stall_pc;
  logic        stall_if;
  logic        stall_id;
  logic        unused_stall;

  assign br_e     = br_bus[32];
  assign br_addr  = br_bus[31:0];
  assign stall_pc = stall[0];
  assign stall_if = stall[1];
  assign stall_id = stall[2];

  // Upper stall bits belong to later stages.
  assign unused_stall = ^stall;

  // Fetch is enabled from the first PC advance after reset until the next
  // reset; deriving it from the state keeps the SRAM idle throughout S_RST.
  assign ce = (state != S_RST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:   if (!stall_pc) state_nxt = S_RUN;
      S_RUN:   if (stall_id)  state_nxt = S_HOLD;
      S_HOLD:  if (!stall_id) state_nxt = S_RUN;
      default: state_nxt = S_RST;
    endcase
  end

  // A live branch wins over a branch that was parked while the PC was
  // stalled; sequential fetch wraps naturally at 2^32.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (pend_valid) begin
      next_pc = pend_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // PC, pending branch, hold buffer and bubble
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      hold_valid <= 1'b0;
      hold_reg   <= 32'd0;
      bubble     <= 1'b0;
    end else begin
      if (!stall_pc) begin
        pc_reg     <= next_pc;
        pend_valid <= 1'b0;
      end else if (br_e && !stall_id) begin
        // ID moves on while the PC is frozen, so the redirect would be lost
        // unless it is parked here. If ID is also stalled, it will present
        // the same branch again and nothing needs to be remembered.
        pend_valid <= 1'b1;
        pend_addr  <= br_addr;
      end

      // The SRAM word is only valid for one cycle; capture it on the first
      // cycle of an ID stall and keep it until ID advances.
      if (stall_id) begin
        if (!hold_valid) begin
          hold_reg   <= sram.inst_sram_rdata;
          hold_valid <= 1'b1;
        end
      end else begin
        hold_valid <= 1'b0;
      end

      // IF stalled but ID advancing: ID receives an empty slot next cycle.
      bubble <= stall_if & ~stall_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    id_inst = sram.inst_sram_rdata;
    if (bubble) begin
      id_inst = 32'd0;
    end else if (hold_valid) begin
      id_inst = hold_reg;
    end else if (!ce) begin
      id_inst = 32'd0;
    end
  end

  assign if_to_id_bus         = {ce, pc_reg};
  assign sram.inst_sram_en    = ce;
  assign sram.inst_sram_wen   = 4'b0000;
  assign sram.inst_sram_addr  = pc_reg;
  assign sram.inst_sram_wdata = 32'd0;

endmodule
`default_nettype wire
